// File: rtl/fetch_pkg.sv
// Shared types for the dual-issue fetch stage: queue entry layout, FSM states
// and the redirect-target priority helper.
package fetch_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_WIDTH    = 32;
  localparam int FQ_DEPTH_DEFAULT = 4;
  localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr1;
    logic [INSTR_WIDTH-1:0] instr2;
  } fq_entry_t;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // Flush beats branch beats jump; jump_pc is the fallback.
  function automatic logic [PC_WIDTH-1:0] select_target(
    input logic                flush_en,
    input logic [PC_WIDTH-1:0] flush_pc,
    input logic                branch_en,
    input logic [PC_WIDTH-1:0] branch_pc,
    input logic [PC_WIDTH-1:0] jump_pc
  );
    if (flush_en) begin
      return flush_pc;
    end else if (branch_en) begin
      return branch_pc;
    end
    return jump_pc;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of instruction-memory, ROB redirect/stall and decoder signals around
// the fetch stage. master = fetch unit, slave = surrounding core/memory.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic                   imem_req_o;
  logic [PC_WIDTH-1:0]    imem_addr_o;
  logic                   imem_valid_i;
  logic [INSTR_WIDTH-1:0] imem_data1_i;
  logic [INSTR_WIDTH-1:0] imem_data2_i;

  logic                   rob_full_i;
  logic                   flush_en_i;
  logic [PC_WIDTH-1:0]    flush_PC_i;
  logic                   branch_en_i;
  logic [PC_WIDTH-1:0]    branch_PC_i;
  logic                   jump_en_i;
  logic [PC_WIDTH-1:0]    jump_PC_i;

  logic [INSTR_WIDTH-1:0] instruction1_o;
  logic                   ins1_valid_o;
  logic [PC_WIDTH-1:0]    PC1_o;
  logic [INSTR_WIDTH-1:0] instruction2_o;
  logic                   ins2_valid_o;
  logic [PC_WIDTH-1:0]    PC2_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_valid_i, imem_data1_i, imem_data2_i,
    input  rob_full_i, flush_en_i, flush_PC_i, branch_en_i, branch_PC_i,
    input  jump_en_i, jump_PC_i,
    output instruction1_o, ins1_valid_o, PC1_o,
    output instruction2_o, ins2_valid_o, PC2_o
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_valid_i, imem_data1_i, imem_data2_i,
    output rob_full_i, flush_en_i, flush_PC_i, branch_en_i, branch_PC_i,
    output jump_en_i, jump_PC_i,
    input  instruction1_o, ins1_valid_o, PC1_o,
    input  instruction2_o, ins2_valid_o, PC2_o
  );

endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: small FIFO of instruction pairs with a combinational head,
// synchronous clear, and push+pop allowed together at any occupancy.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  fq_entry_t push_data,
  output fq_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t        mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  // A simultaneous pop frees the slot the push needs.
  assign do_push = push && (!full || do_pop) && !clear;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: PC register, request FSM towards instruction memory,
// redirect handling and the decoder-facing pair port fed from the fetch queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  FQ_DEPTH = FQ_DEPTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_e        state_reg;
  fetch_state_e        state_next;
  logic [PC_WIDTH-1:0] fetch_pc_reg;
  logic [PC_WIDTH-1:0] fetch_pc_next;

  logic                redirect;
  logic [PC_WIDTH-1:0] target;
  logic                req;
  logic                dec_valid;

  logic                q_push;
  logic                q_full;
  logic                q_empty;
  fq_entry_t           q_head;
  fq_entry_t           q_push_data;

  assign redirect = bus.flush_en_i | bus.branch_en_i | bus.jump_en_i;
  assign target   = select_target(bus.flush_en_i, bus.flush_PC_i,
                                  bus.branch_en_i, bus.branch_PC_i,
                                  bus.jump_PC_i);

  assign q_push_data = '{pc: fetch_pc_reg, instr1: bus.imem_data1_i, instr2: bus.imem_data2_i};

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .pop       (dec_valid),
    .clear     (redirect),
    .push_data (q_push_data),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= REQ;
      fetch_pc_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    q_push        = 1'b0;
    req           = 1'b0;
    case (state_reg)
      REQ: begin
        // A redirect suppresses the issue so the old address is never accepted.
        if (redirect) begin
          fetch_pc_next = target;
        end else if (!q_full) begin
          req        = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (redirect) begin
          fetch_pc_next = target;
          state_next    = bus.imem_valid_i ? REQ : DISCARD;
        end else if (bus.imem_valid_i) begin
          q_push        = 1'b1;
          fetch_pc_next = fetch_pc_reg + PC_WIDTH'(8);
          state_next    = REQ;
        end
      end
      DISCARD: begin
        if (redirect) begin
          fetch_pc_next = target;
        end
        if (bus.imem_valid_i) begin
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
  end

  // Request is forced low while reset is held, since state REQ is the reset state.
  assign bus.imem_req_o  = req & rst;
  assign bus.imem_addr_o = fetch_pc_reg;

  assign dec_valid          = !q_empty && !bus.rob_full_i && !redirect;
  assign bus.ins1_valid_o   = dec_valid;
  assign bus.ins2_valid_o   = dec_valid;
  assign bus.instruction1_o = q_empty ? '0 : q_head.instr1;
  assign bus.instruction2_o = q_empty ? '0 : q_head.instr2;
  assign bus.PC1_o          = q_empty ? '0 : q_head.pc;
  assign bus.PC2_o          = q_empty ? '0 : q_head.pc + PC_WIDTH'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: one vector per cycle, the
// instruction memory response is part of each vector.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk;
  logic rst;
  fetch_unit_if bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rf;
    logic [2:0]  redir;  // {flush, branch, jump}
    logic [31:0] fpc;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic        iv;
    logic [31:0] maddr;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc1;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl [34];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic vec_t mk(input logic rf, input logic [2:0] redir,
                              input logic [31:0] fpc, input logic [31:0] bpc,
                              input logic [31:0] jpc, input logic iv,
                              input logic [31:0] maddr, input logic ereq,
                              input logic [31:0] eaddr, input logic ev,
                              input logic [31:0] epc1);
    vec_t v;
    v.rf = rf; v.redir = redir; v.fpc = fpc; v.bpc = bpc; v.jpc = jpc;
    v.iv = iv; v.maddr = maddr; v.ereq = ereq; v.eaddr = eaddr;
    v.ev = ev; v.epc1 = epc1;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int id);
    logic [31:0] epc2;
    logic ok;
    bus.rob_full_i   = v.rf;
    bus.flush_en_i   = v.redir[2];
    bus.branch_en_i  = v.redir[1];
    bus.jump_en_i    = v.redir[0];
    bus.flush_PC_i   = v.fpc;
    bus.branch_PC_i  = v.bpc;
    bus.jump_PC_i    = v.jpc;
    bus.imem_valid_i = v.iv;
    bus.imem_data1_i = v.iv ? instr_of(v.maddr) : 32'hBAD0_BAD0;
    bus.imem_data2_i = v.iv ? instr_of(v.maddr + 32'd4) : 32'hBAD0_BAD0;
    #1;
    epc2 = v.epc1 + 32'd4;
    ok = (bus.imem_req_o == v.ereq)
      && (!v.ereq || bus.imem_addr_o == v.eaddr)
      && (bus.ins1_valid_o == v.ev) && (bus.ins2_valid_o == v.ev)
      && (!v.ev || (bus.PC1_o == v.epc1 && bus.PC2_o == epc2
                    && bus.instruction1_o == instr_of(v.epc1)
                    && bus.instruction2_o == instr_of(epc2)));
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d: got req=%0b addr=%h v=%0b%0b pc1=%h pc2=%h i1=%h i2=%h, want req=%0b addr=%h v=%0b pc1=%h",
               id, bus.imem_req_o, bus.imem_addr_o, bus.ins1_valid_o, bus.ins2_valid_o,
               bus.PC1_o, bus.PC2_o, bus.instruction1_o, bus.instruction2_o,
               v.ereq, v.eaddr, v.ev, v.epc1);
    end else begin
      $display("vec%0d ok: req=%0b addr=%h v=%0b pc1=%h", id, bus.imem_req_o,
               bus.imem_addr_o, bus.ins1_valid_o, bus.PC1_o);
    end
  endtask

  task automatic chk_zero(input int id);
    logic ok;
    ok = (bus.imem_req_o == 1'b0) && !bus.ins1_valid_o && !bus.ins2_valid_o
      && (bus.PC1_o == '0) && (bus.PC2_o == '0)
      && (bus.instruction1_o == '0) && (bus.instruction2_o == '0);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL reset%0d: got req=%0b v=%0b%0b pc1=%h pc2=%h i1=%h i2=%h, want all 0",
               id, bus.imem_req_o, bus.ins1_valid_o, bus.ins2_valid_o,
               bus.PC1_o, bus.PC2_o, bus.instruction1_o, bus.instruction2_o);
    end else begin
      $display("reset%0d ok: outputs all zero", id);
    end
  endtask

  task automatic idle_inputs();
    bus.rob_full_i = 0; bus.flush_en_i = 0; bus.branch_en_i = 0; bus.jump_en_i = 0;
    bus.flush_PC_i = '0; bus.branch_PC_i = '0; bus.jump_PC_i = '0;
    bus.imem_valid_i = 0; bus.imem_data1_i = '0; bus.imem_data2_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming with 1-cycle memory latency
    tbl[0]  = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'h0,        0,32'h0);
    tbl[1]  = mk(0,3'b000,0,0,0, 1,32'h0,        1,32'h0,        0,32'h0);
    tbl[2]  = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'h8,        1,32'h0);
    tbl[3]  = mk(0,3'b000,0,0,0, 1,32'h8,        1,32'h8,        0,32'h0);
    tbl[4]  = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'h10,       1,32'h8);
    tbl[5]  = mk(0,3'b000,0,0,0, 1,32'h10,       1,32'h10,       0,32'h0);
    tbl[6]  = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'h18,       1,32'h10);
    // ROB full: four pairs fill the queue, then requests stop
    tbl[7]  = mk(1,3'b000,0,0,0, 1,32'h18,       1,32'h18,       0,32'h0);
    tbl[8]  = mk(1,3'b000,0,0,0, 0,32'h0,        1,32'h20,       0,32'h0);
    tbl[9]  = mk(1,3'b000,0,0,0, 1,32'h20,       1,32'h20,       0,32'h0);
    tbl[10] = mk(1,3'b000,0,0,0, 0,32'h0,        1,32'h28,       0,32'h0);
    tbl[11] = mk(1,3'b000,0,0,0, 1,32'h28,       1,32'h28,       0,32'h0);
    tbl[12] = mk(1,3'b000,0,0,0, 0,32'h0,        1,32'h30,       0,32'h0);
    tbl[13] = mk(1,3'b000,0,0,0, 1,32'h30,       1,32'h30,       0,32'h0);
    tbl[14] = mk(1,3'b000,0,0,0, 0,32'h0,        0,32'h0,        0,32'h0);
    tbl[15] = mk(1,3'b000,0,0,0, 0,32'h0,        0,32'h0,        0,32'h0);
    // Release: drain in order while fetch resumes
    tbl[16] = mk(0,3'b000,0,0,0, 0,32'h0,        0,32'h0,        1,32'h18);
    tbl[17] = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'h38,       1,32'h20);
    tbl[18] = mk(0,3'b000,0,0,0, 1,32'h38,       1,32'h38,       1,32'h28);
    tbl[19] = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'h40,       1,32'h30);
    tbl[20] = mk(0,3'b000,0,0,0, 1,32'h40,       1,32'h40,       1,32'h38);
    tbl[21] = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'h48,       1,32'h40);
    tbl[22] = mk(0,3'b000,0,0,0, 1,32'h48,       1,32'h48,       0,32'h0);
    // All three redirects at once with one entry queued: flush wins
    tbl[23] = mk(0,3'b111,32'h200,32'h300,32'h400, 0,32'h0, 0,32'h0, 0,32'h0);
    tbl[24] = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'h200,      0,32'h0);
    tbl[25] = mk(0,3'b000,0,0,0, 1,32'h200,      1,32'h200,      0,32'h0);
    tbl[26] = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'h208,      1,32'h200);
    // Jump near the top of the address space, killing the WAIT request
    tbl[27] = mk(0,3'b001,0,0,32'hFFFF_FFF8, 0,32'h0, 1,32'h208, 0,32'h0);
    tbl[28] = mk(0,3'b000,0,0,0, 1,32'h208,      0,32'h0,        0,32'h0);
    tbl[29] = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'hFFFF_FFF8, 0,32'h0);
    tbl[30] = mk(0,3'b000,0,0,0, 1,32'hFFFF_FFF8, 1,32'hFFFF_FFF8, 0,32'h0);
    tbl[31] = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'h0,        1,32'hFFFF_FFF8);
    tbl[32] = mk(0,3'b000,0,0,0, 1,32'h0,        1,32'h0,        0,32'h0);
    tbl[33] = mk(0,3'b000,0,0,0, 0,32'h0,        1,32'h8,        1,32'h0);

    idle_inputs();
    rst = 1'b0;
    @(negedge clk); #1;
    chk_zero(0);
    @(negedge clk);
    rst = 1'b1;
    apply_vec(tbl[0], 0);
    for (int i = 1; i < 34; i++) begin
      @(negedge clk);
      apply_vec(tbl[i], i);
    end

    // Branch while waiting on a 3-cycle response: stale data must be dropped
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 1,32'h8,   1,32'h8,   0,32'h0),   100);
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 0,32'h0,   1,32'h10,  1,32'h8),   101);
    @(negedge clk); apply_vec(mk(0,3'b010,0,32'h100,0, 0,32'h0, 1,32'h10, 0,32'h0), 102);
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 0,32'h0,   0,32'h0,   0,32'h0),   103);
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 1,32'h10,  0,32'h0,   0,32'h0),   104);
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 0,32'h0,   1,32'h100, 0,32'h0),   105);
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 0,32'h0,   1,32'h100, 0,32'h0),   106);
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 0,32'h0,   1,32'h100, 0,32'h0),   107);
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 1,32'h100, 1,32'h100, 0,32'h0),   108);
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 0,32'h0,   1,32'h108, 1,32'h100), 109);
    // Jump in the same cycle as the response: response dropped
    @(negedge clk); apply_vec(mk(0,3'b001,0,0,32'h40, 1,32'h108, 1,32'h108, 0,32'h0), 110);
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 0,32'h0,   1,32'h40,  0,32'h0),   111);

    // Fill three entries under ROB full, then reset mid-WAIT
    @(negedge clk); apply_vec(mk(1,3'b000,0,0,0, 1,32'h40,  1,32'h40,  0,32'h0),   200);
    @(negedge clk); apply_vec(mk(1,3'b000,0,0,0, 0,32'h0,   1,32'h48,  0,32'h0),   201);
    @(negedge clk); apply_vec(mk(1,3'b000,0,0,0, 1,32'h48,  1,32'h48,  0,32'h0),   202);
    @(negedge clk); apply_vec(mk(1,3'b000,0,0,0, 0,32'h0,   1,32'h50,  0,32'h0),   203);
    @(negedge clk); apply_vec(mk(1,3'b000,0,0,0, 1,32'h50,  1,32'h50,  0,32'h0),   204);
    @(negedge clk); apply_vec(mk(1,3'b000,0,0,0, 0,32'h0,   1,32'h58,  0,32'h0),   205);
    @(negedge clk); apply_vec(mk(1,3'b000,0,0,0, 0,32'h0,   1,32'h58,  0,32'h0),   206);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    chk_zero(1);
    @(negedge clk); #1;
    chk_zero(2);
    @(negedge clk);
    rst = 1'b1;
    apply_vec(mk(0,3'b000,0,0,0, 0,32'h0, 1,32'h0, 0,32'h0), 210);
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 1,32'h0,   1,32'h0,   0,32'h0),   211);
    @(negedge clk); apply_vec(mk(0,3'b000,0,0,0, 0,32'h0,   1,32'h8,   1,32'h0),   212);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
